// File: rtl/ram_tech_pkg.sv
// Shared types and helpers for the ram_tech dual-port RAM.
// Build option: define RAM_TECH_PARITY_EN to store one even-parity bit per byte lane.
package ram_tech_pkg;

    // Controller states: CLEAR zero-fills the array, READY serves accesses.
    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

`ifdef RAM_TECH_PARITY_EN
    // Each stored lane carries 8 data bits plus its parity bit in bit 8.
    localparam int LANE_BITS = 9;
`else
    localparam int LANE_BITS = 8;
`endif

    // Even parity of one byte: 1 when the byte holds an odd number of ones.
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/ram_tech_bank.sv
// Storage bank: one inferred array per byte lane, one write port and one
// synchronous read port. Reads return the pre-write contents on a collision;
// the controller above resolves same-address bypass. Storage is never reset.
module ram_tech_bank
    import ram_tech_pkg::*;
#(
    parameter int abits = 12,
    parameter int lanes = 8,
    parameter int lbits = LANE_BITS
) (
    input  logic                     i_clk,
    input  logic                     i_wena,
    input  logic [abits-1:0]         i_waddr,
    input  logic [lanes-1:0]         i_wstrb,
    input  logic [lanes*lbits-1:0]   i_wdata,
    input  logic                     i_rena,
    input  logic [abits-1:0]         i_raddr,
    output logic [lanes*lbits-1:0]   o_rdata
);

    localparam int depth = 2 ** abits;

    genvar gi;
    generate
        for (gi = 0; gi < lanes; gi++) begin : g_lane
            logic [lbits-1:0] mem_reg [depth];
            logic [lbits-1:0] rd_reg;

            // Byte-lane write and registered read; read data holds when idle.
            always_ff @(posedge i_clk) begin
                if (i_wena && i_wstrb[gi]) begin
                    mem_reg[i_waddr] <= i_wdata[gi*lbits +: lbits];
                end
                if (i_rena) begin
                    rd_reg <= mem_reg[i_raddr];
                end
            end

            assign o_rdata[gi*lbits +: lbits] = rd_reg;
        end
    endgenerate

endmodule

// File: rtl/ram_tech_dp.sv
// Dual-port RAM controller: post-reset zero-fill, per-lane write-first bypass
// on same-address read/write, optional per-byte parity checking.
// Build option: define RAM_TECH_PARITY_EN to enable parity storage and o_perr.
module ram_tech_dp
    import ram_tech_pkg::*;
#(
    parameter int abits      = 12,
    parameter int dbits      = 64,
    parameter int init_clear = 1
) (
    input  logic                 i_clk,
    input  logic                 i_nrst,
    output logic                 o_ready,
    input  logic                 i_wena,
    input  logic [abits-1:0]     i_waddr,
    input  logic [dbits/8-1:0]   i_wstrb,
    input  logic [dbits-1:0]     i_wdata,
    input  logic                 i_rena,
    input  logic [abits-1:0]     i_raddr,
    output logic                 o_rvalid,
    output logic [dbits-1:0]     o_rdata,
    output logic                 o_perr
);

    localparam int lanes = dbits / 8;
    localparam int wbits = lanes * LANE_BITS;

    state_t               state_reg, state_next;
    logic [abits-1:0]     clr_cnt_reg, clr_cnt_next;
    logic                 rvalid_reg;
    logic                 rd_seen_reg;
    logic [lanes-1:0]     byp_mask_reg;
    logic [dbits-1:0]     byp_data_reg;

    logic                 ready;
    logic                 clear_active;
    logic                 rd_fire;
    logic                 bank_wena;
    logic [abits-1:0]     bank_waddr;
    logic [lanes-1:0]     bank_wstrb;
    logic [wbits-1:0]     bank_wdata;
    logic [wbits-1:0]     user_wword;
    logic [wbits-1:0]     bank_rdata;
    logic [dbits-1:0]     merged_data;
    logic [lanes-1:0]     lane_err;

    assign ready        = (state_reg == READY);
    assign clear_active = (state_reg == CLEAR) && (init_clear != 0);
    assign rd_fire      = ready && i_rena;

    // Next-state and clear-address walk: one word per cycle until the last.
    always_comb begin
        state_next   = state_reg;
        clr_cnt_next = clr_cnt_reg;
        case (state_reg)
            CLEAR: begin
                if (init_clear == 0) begin
                    state_next = READY;
                end else begin
                    clr_cnt_next = clr_cnt_reg + 1'b1;
                    if (clr_cnt_reg == '1) begin
                        state_next = READY;
                    end
                end
            end
            READY: begin
                state_next = READY;
            end
            default: begin
                state_next = CLEAR;
            end
        endcase
    end

    // State and clear counter registers.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_reg   <= CLEAR;
            clr_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_cnt_reg <= clr_cnt_next;
        end
    end

    // Read-side registers: valid strobe, and which lanes bypass from write data.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            rvalid_reg   <= 1'b0;
            rd_seen_reg  <= 1'b0;
            byp_mask_reg <= '0;
            byp_data_reg <= '0;
        end else begin
            rvalid_reg <= rd_fire;
            if (rd_fire) begin
                rd_seen_reg  <= 1'b1;
                byp_mask_reg <= (i_wena && (i_waddr == i_raddr)) ? i_wstrb : '0;
                byp_data_reg <= i_wdata;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < lanes; gi++) begin : g_lane
            assign user_wword[gi*LANE_BITS +: 8] = i_wdata[gi*8 +: 8];
`ifdef RAM_TECH_PARITY_EN
            assign user_wword[gi*LANE_BITS + 8] = byte_parity(i_wdata[gi*8 +: 8]);
            // Bypassed lanes come straight from write data and cannot be corrupt.
            assign lane_err[gi] = !byp_mask_reg[gi] &&
                (byte_parity(bank_rdata[gi*LANE_BITS +: 8]) != bank_rdata[gi*LANE_BITS + 8]);
`else
            assign lane_err[gi] = 1'b0;
`endif
            assign merged_data[gi*8 +: 8] = byp_mask_reg[gi] ? byp_data_reg[gi*8 +: 8]
                                                             : bank_rdata[gi*LANE_BITS +: 8];
        end
    endgenerate

    // During CLEAR the bank port is owned by the zero-fill walk.
    assign bank_wena  = clear_active || (ready && i_wena);
    assign bank_waddr = clear_active ? clr_cnt_reg : i_waddr;
    assign bank_wstrb = clear_active ? '1 : i_wstrb;
    assign bank_wdata = clear_active ? '0 : user_wword;

    ram_tech_bank #(
        .abits (abits),
        .lanes (lanes),
        .lbits (LANE_BITS)
    ) u_bank (
        .i_clk   (i_clk),
        .i_wena  (bank_wena),
        .i_waddr (bank_waddr),
        .i_wstrb (bank_wstrb),
        .i_wdata (bank_wdata),
        .i_rena  (rd_fire),
        .i_raddr (i_raddr),
        .o_rdata (bank_rdata)
    );

    // Outputs read zero until the first read after reset; afterwards they hold.
    assign o_ready  = ready;
    assign o_rvalid = rvalid_reg;
    assign o_rdata  = rd_seen_reg ? merged_data : '0;
`ifdef RAM_TECH_PARITY_EN
    assign o_perr   = rd_seen_reg && (|lane_err);
`else
    assign o_perr   = 1'b0;
`endif

endmodule

// File: tb/tb_ram_tech_dp.sv
// Testbench for ram_tech_dp (abits=4, dbits=64, init_clear=1). Reads push
// expected {perr, data} into a queue; a monitor pops on every o_rvalid.
// Honours RAM_TECH_PARITY_EN for the parity-corruption expectation.
module tb_ram_tech_dp;

    logic        i_clk = 1'b0;
    logic        i_nrst;
    logic        o_ready;
    logic        i_wena;
    logic [3:0]  i_waddr;
    logic [7:0]  i_wstrb;
    logic [63:0] i_wdata;
    logic        i_rena;
    logic [3:0]  i_raddr;
    logic        o_rvalid;
    logic [63:0] o_rdata;
    logic        o_perr;

    int checks = 0;
    int errors = 0;
    logic [64:0] exp_q[$];

`ifdef RAM_TECH_PARITY_EN
    localparam logic PERR_ON_FLIP = 1'b1;
`else
    localparam logic PERR_ON_FLIP = 1'b0;
`endif

    ram_tech_dp #(
        .abits      (4),
        .dbits      (64),
        .init_clear (1)
    ) u_dut (
        .i_clk    (i_clk),
        .i_nrst   (i_nrst),
        .o_ready  (o_ready),
        .i_wena   (i_wena),
        .i_waddr  (i_waddr),
        .i_wstrb  (i_wstrb),
        .i_wdata  (i_wdata),
        .i_rena   (i_rena),
        .i_raddr  (i_raddr),
        .o_rvalid (o_rvalid),
        .o_rdata  (o_rdata),
        .o_perr   (o_perr)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end else begin
            $display("ok   %s value=%h", name, act);
        end
    endtask

    // One cycle of stimulus, driven at the falling edge.
    task automatic drive(input logic we, input logic [3:0] wa, input logic [7:0] ws,
                         input logic [63:0] wd, input logic re, input logic [3:0] ra,
                         input logic [63:0] exp_d, input logic exp_p);
        @(negedge i_clk);
        i_wena  = we;
        i_waddr = wa;
        i_wstrb = ws;
        i_wdata = wd;
        i_rena  = re;
        i_raddr = ra;
        if (re) exp_q.push_back({exp_p, exp_d});
    endtask

    task automatic idle();
        @(negedge i_clk);
        i_wena = 1'b0;
        i_rena = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},  {63'd0, o_ready},  64'd0);
        check({tag, "_rvalid"}, {63'd0, o_rvalid}, 64'd0);
        check({tag, "_rdata"},  o_rdata,           64'd0);
        check({tag, "_perr"},   {63'd0, o_perr},   64'd0);
    endtask

    // o_ready must be low after edges 1..15 and high after edge 16.
    // Optionally pulses reads/writes mid-clear; they must have no effect.
    task automatic wait_clear(input string tag, input bit poke);
        for (int cyc = 1; cyc <= 16; cyc++) begin
            @(posedge i_clk);
            #1;
            check($sformatf("%s_ready_c%0d", tag, cyc), {63'd0, o_ready},
                  (cyc == 16) ? 64'd1 : 64'd0);
            if (poke) begin
                if (cyc == 8) begin
                    i_wena = 1'b1; i_waddr = 4'd4; i_wstrb = 8'hFF;
                    i_wdata = 64'hDEAD_BEEF_DEAD_BEEF;
                    i_rena = 1'b1; i_raddr = 4'd4;
                end else if (cyc == 11) begin
                    i_wena = 1'b0; i_rena = 1'b0;
                end
            end
        end
    endtask

    // Monitor: every o_rvalid must match the oldest outstanding expectation.
    initial begin
        logic [64:0] e;
        forever begin
            @(posedge i_clk);
            #1;
            if (o_rvalid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rvalid actual rdata=%h perr=%b required no read", o_rdata, o_perr);
                end else begin
                    e = exp_q.pop_front();
                    if (o_rdata !== e[63:0] || o_perr !== e[64]) begin
                        errors++;
                        $display("FAIL read actual rdata=%h perr=%b required rdata=%h perr=%b",
                                 o_rdata, o_perr, e[63:0], e[64]);
                    end else begin
                        $display("ok   read rdata=%h perr=%b", o_rdata, o_perr);
                    end
                end
            end
        end
    end

    initial begin
        i_nrst = 1'b0;
        i_wena = 1'b0; i_waddr = '0; i_wstrb = '0; i_wdata = '0;
        i_rena = 1'b0; i_raddr = '0;
        repeat (3) @(posedge i_clk);
        #1;
        check_reset_outputs("rst");

        // Release reset away from the clock edge, poke ports during CLEAR.
        @(negedge i_clk);
        i_nrst = 1'b1;
        wait_clear("clr", 1'b1);

        // Every address reads back zero after the fill.
        for (int a = 0; a < 16; a++) begin
            drive(1'b0, 4'd0, 8'h00, 64'd0, 1'b1, a[3:0], 64'd0, 1'b0);
        end

        // Full write, partial write, then read back.
        drive(1'b1, 4'd3, 8'hFF, 64'h1122_3344_5566_7788, 1'b0, 4'd0, 64'd0, 1'b0);
        drive(1'b1, 4'd3, 8'h0F, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 4'd0, 64'd0, 1'b0);
        drive(1'b0, 4'd0, 8'h00, 64'd0, 1'b1, 4'd3, 64'h1122_3344_AAAA_AAAA, 1'b0);
        // Same-address collision: strobed lanes new, others old.
        drive(1'b1, 4'd5, 8'h01, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'd5, 64'h0000_0000_0000_00FF, 1'b0);
        drive(1'b1, 4'd3, 8'hF0, 64'h5555_5555_5555_5555, 1'b1, 4'd3, 64'h5555_5555_AAAA_AAAA, 1'b0);
        // Different addresses in the same cycle do not interact.
        drive(1'b1, 4'd6, 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b1, 4'd3, 64'h5555_5555_AAAA_AAAA, 1'b0);
        drive(1'b0, 4'd0, 8'h00, 64'd0, 1'b1, 4'd5, 64'h0000_0000_0000_00FF, 1'b0);
        // Address 4 was poked during CLEAR and must still be zero.
        drive(1'b0, 4'd0, 8'h00, 64'd0, 1'b1, 4'd4, 64'd0, 1'b0);
        // A write with no strobes leaves the word alone.
        drive(1'b1, 4'd6, 8'h00, 64'd0, 1'b1, 4'd6, 64'h0123_4567_89AB_CDEF, 1'b0);
        idle();
        @(negedge i_clk);
        check("hold_rvalid", {63'd0, o_rvalid}, 64'd0);
        check("hold_rdata",  o_rdata, 64'h0123_4567_89AB_CDEF);

        // Corrupt data bit 9 of address 2 behind the controller's back.
        u_dut.u_bank.g_lane[1].mem_reg[2][1] = ~u_dut.u_bank.g_lane[1].mem_reg[2][1];
        drive(1'b0, 4'd0, 8'h00, 64'd0, 1'b1, 4'd2, 64'h0000_0000_0000_0200, PERR_ON_FLIP);
        idle();
        @(negedge i_clk);
        check("hold_perr", {63'd0, o_perr}, {63'd0, PERR_ON_FLIP});

        // Reset in the middle of CLEAR restarts the full walk.
        i_nrst = 1'b0;
        #1;
        check_reset_outputs("rst2");
        @(negedge i_clk);
        i_nrst = 1'b1;
        repeat (7) @(posedge i_clk);
        @(negedge i_clk);
        i_nrst = 1'b0;
        #1;
        check_reset_outputs("rst3");
        @(negedge i_clk);
        i_nrst = 1'b1;
        wait_clear("reclr", 1'b0);

        drive(1'b0, 4'd0, 8'h00, 64'd0, 1'b1, 4'd3, 64'd0, 1'b0);
        drive(1'b0, 4'd0, 8'h00, 64'd0, 1'b1, 4'd2, 64'd0, 1'b0);
        idle();
        repeat (3) @(negedge i_clk);
        check("pending_reads", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
